// File: rtl/cordic_div_pkg.sv
// ============================================================================
// Module      : cordic_div_pkg
// Description : Shared state encoding and saturation helper for the
//               linear-mode CORDIC sequential divider.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package cordic_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_CORR = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Largest positive magnitude of a w-bit signed value: 2^(w-1)-1
    function automatic logic [63:0] sat_mag(input int unsigned w);
        sat_mag = (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_lin_step.sv
// ============================================================================
// Module      : cordic_lin_step
// Description : One combinational linear-mode CORDIC digit. Moves the
//               residual toward zero by X*2^s and books +/-2^s into the
//               quotient accumulator.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module cordic_lin_step #(
    parameter int YW = 17,
    parameter int XW = 8,
    parameter int ZW = 8,
    parameter int SW = 3
) (
    input  logic signed [YW-1:0] y,
    input  logic        [XW-1:0] x,
    input  logic signed [ZW-1:0] z,
    input  logic        [SW-1:0] s,
    input  logic                 dir,     // 1: residual non-negative, subtract
    output logic signed [YW-1:0] y_next,
    output logic signed [ZW-1:0] z_next
);

    logic [YW-1:0] x_term;
    logic [ZW-1:0] z_term;

    // Shifted divisor and digit weight replace the old 2^-i table
    always_comb begin
        x_term = {{(YW-XW){1'b0}}, x} << s;
        z_term = {{(ZW-1){1'b0}}, 1'b1} << s;
        if (dir) begin
            y_next = y - $signed(x_term);
            z_next = z + $signed(z_term);
        end else begin
            y_next = y + $signed(x_term);
            z_next = z - $signed(z_term);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_div_seq.sv
// ============================================================================
// Module      : cordic_div_seq
// Description : Sequential signed divider, quotient =
//               trunc((dividend * 2^FRAC) / divisor), using non-restoring
//               linear CORDIC digits, valid/ready handshake, saturation
//               with ovf/dbz flags and optional early exit.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module cordic_div_seq
    import cordic_div_pkg::*;
#(
    parameter int W          = 8,
    parameter int FRAC       = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic         ovf,
    output logic         dbz
);

    localparam int YW = 2 * W + FRAC + 1;
    localparam int SW = $clog2(W);
    localparam logic [63:0]  SAT64   = sat_mag(W);
    localparam logic [W-1:0] SAT_POS = SAT64[W-1:0];
    localparam logic [W-1:0] SAT_NEG = -SAT_POS;

    state_t state, next_state;

    logic [W-1:0]         dvd_q, dvs_q, abs_d;
    logic                 sign_q, load_phase;
    logic signed [YW-1:0] y, y_next;
    logic signed [W-1:0]  z, z_next;
    logic [SW-1:0]        k, s;

    logic [W-1:0]  dvd_mag, dvs_mag, z_corr, corr_q;
    logic [YW-1:0] x_limit;
    logic          ovf_cond, res_zero, last_digit;

    // Magnitudes, range test, digit shift and the final correction
    always_comb begin
        dvd_mag    = dvd_q[W-1] ? -dvd_q : dvd_q;
        dvs_mag    = dvs_q[W-1] ? -dvs_q : dvs_q;
        x_limit    = {{(YW-W){1'b0}}, abs_d} << (W - 1);
        ovf_cond   = $unsigned(y) >= x_limit;
        res_zero   = (EARLY_EXIT != 0) && (y == '0);
        last_digit = (k == SW'(W - 2));
        s          = SW'(W - 2) - k;
        z_corr     = y[YW-1] ? $unsigned(z) - W'(1) : $unsigned(z);
        corr_q     = sign_q ? -z_corr : z_corr;
    end

    cordic_lin_step #(
        .YW (YW),
        .XW (W),
        .ZW (W),
        .SW (SW)
    ) u_step (
        .y      (y),
        .x      (abs_d),
        .z      (z),
        .s      (s),
        .dir    (~y[YW-1]),
        .y_next (y_next),
        .z_next (z_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_phase) begin
                    if (abs_d == '0 || ovf_cond) next_state = ST_DONE;
                    else                         next_state = ST_ITER;
                end
            end
            ST_ITER: begin
                if (res_zero || last_digit) next_state = ST_CORR;
            end
            ST_CORR: next_state = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, two-cycle load, digit iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q      <= '0;
            dvs_q      <= '0;
            abs_d      <= '0;
            sign_q     <= 1'b0;
            load_phase <= 1'b0;
            y          <= '0;
            z          <= '0;
            k          <= '0;
            quotient   <= '0;
            ovf        <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        load_phase <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!load_phase) begin
                        load_phase <= 1'b1;
                        abs_d      <= dvs_mag;
                        sign_q     <= dvd_q[W-1] ^ dvs_q[W-1];
                        y          <= $signed({{(YW-W){1'b0}}, dvd_mag}) <<< FRAC;
                        z          <= '0;
                        k          <= '0;
                    end else begin
                        load_phase <= 1'b0;
                        if (abs_d == '0) begin
                            quotient <= dvd_q[W-1] ? SAT_NEG : SAT_POS;
                            dbz      <= 1'b1;
                            ovf      <= 1'b0;
                        end else if (ovf_cond) begin
                            quotient <= sign_q ? SAT_NEG : SAT_POS;
                            ovf      <= 1'b1;
                            dbz      <= 1'b0;
                        end
                    end
                end
                ST_ITER: begin
                    if (!res_zero) begin
                        y <= y_next;
                        z <= z_next;
                        k <= k + SW'(1);
                    end
                end
                ST_CORR: begin
                    quotient <= corr_q;
                    ovf      <= 1'b0;
                    dbz      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
